// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, header base
// and the scheduler state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_BASE_DEFAULT = 8'hA0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SEND,
    WAIT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one above ptr
// and wraps modulo N, so the last winner gets the lowest priority next time.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N requesters, one whole frame per
// grant, with an optional id header byte and a watchdog for stuck frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int                N        = 4,
  parameter int                HDR_EN   = 1,
  parameter logic [BYTE_W-1:0] HDR_BASE = HDR_BASE_DEFAULT,
  parameter logic [15:0]       TIMEOUT  = 16'd50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [BYTE_W*N-1:0] req_data,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_ready,
  output logic [N-1:0]        grant,
  output logic                active,
  output logic                tx_start,
  output logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic                err
);

  localparam int IDX_W = $clog2(N);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] id, id_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N-1:0]     grant_nxt;
  logic             hdr_phase, hdr_nxt;
  logic             last_q, last_nxt;
  logic [15:0]      wd_cnt, wd_nxt;
  logic             err_nxt;
  logic             wd_expired;

  logic [N-1:0]     arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic [BYTE_W-1:0] req_bytes [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // The watchdog overrides every state action, including a same-cycle byte offer.
  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    hdr_nxt   = hdr_phase;
    last_nxt  = last_q;
    err_nxt   = 1'b0;
    tx_start  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    wd_expired = (state != IDLE) && (wd_cnt == TIMEOUT - 16'd1);

    if (wd_expired) begin
      err_nxt   = 1'b1;
      grant_nxt = '0;
      ptr_nxt   = id;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_nxt = arb_gnt;
            id_nxt    = arb_idx;
            hdr_nxt   = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = (HDR_EN != 0) ? HDR : SEND;
          end
        end
        HDR: begin
          if (!tx_busy) begin
            tx_start  = 1'b1;
            tx_data   = HDR_BASE | BYTE_W'(id);
            hdr_nxt   = 1'b1;
            state_nxt = WAIT;
          end
        end
        SEND: begin
          if (req_valid[id] && !tx_busy) begin
            tx_start      = 1'b1;
            tx_data       = req_bytes[id];
            req_ready[id] = 1'b1;
            last_nxt      = req_last[id];
            hdr_nxt       = 1'b0;
            state_nxt     = WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (last_q && !hdr_phase) begin
              state_nxt = IDLE;
              ptr_nxt   = id;
              grant_nxt = '0;
            end else begin
              state_nxt = SEND;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    wd_nxt = ((state_nxt != state) || (state == IDLE)) ? 16'd0 : wd_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      id        <= '0;
      ptr       <= IDX_W'(N - 1);
      grant     <= '0;
      hdr_phase <= 1'b0;
      last_q    <= 1'b0;
      wd_cnt    <= '0;
      err       <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      id        <= id_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      hdr_phase <= hdr_nxt;
      last_q    <= last_nxt;
      wd_cnt    <= wd_nxt;
      err       <= err_nxt;
      active    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued requesters and a 10-cycle transmitter model
// feed a scoreboard that checks every tx_start against hand-computed bytes.
module tb_uart_tx_sched;

  localparam int NR       = 4;
  localparam int BYTE_CYC = 10;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] gnt;
    logic [3:0] rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        active, tx_start, tx_busy, tx_done, err;
  logic [7:0]  tx_data;

  logic [3:0]  r2_valid, r2_last, r2_ready, grant2;
  logic [31:0] r2_data;
  logic        active2, tx2_start, tx2_busy, tx2_done, err2;
  logic [7:0]  tx2_data;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  exp_t expq[$];
  exp_t mon_e;
  logic [8:0] rbuf [NR][32];
  int   rhead [NR];
  int   rtail [NR];
  int   ready_cnt [NR];
  logic [3:0] consumed;
  bit   start_seen;
  bit   done_en;
  bit   model_busy;
  int   busy_cnt;

  uart_tx_sched #(.N(4), .HDR_EN(1), .HDR_BASE(8'hA0), .TIMEOUT(16'd20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .active(active), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .err(err)
  );

  uart_tx_sched #(.N(4), .HDR_EN(0), .HDR_BASE(8'hA0), .TIMEOUT(16'd20)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_data(r2_data), .req_last(r2_last),
    .req_ready(r2_ready), .grant(grant2), .active(active2), .tx_start(tx2_start),
    .tx_data(tx2_data), .tx_busy(tx2_busy), .tx_done(tx2_done), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic refreshReq();
    for (int i = 0; i < NR; i++) begin
      if (rhead[i] < rtail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = rbuf[i][rhead[i]][7:0];
        req_last[i]        = rbuf[i][rhead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Queue a frame on requester r and push the transmitter bytes it should
  // produce: the header plus the first nexp data bytes.
  task automatic applyStimulus(input int r, input int n, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input bit load, input int nexp);
    logic [7:0] d [3];
    exp_t x;
    d[0] = d0; d[1] = d1; d[2] = d2;
    @(posedge clk); #2;
    if (load) begin
      for (int k = 0; k < n; k++) begin
        rbuf[r][rtail[r]] = {(k == n - 1), d[k]};
        rtail[r]++;
      end
    end
    x.data = 8'hA0 | 8'(r); x.gnt = 4'(1 << r); x.rdy = 4'b0000;
    expq.push_back(x);
    for (int k = 0; k < nexp; k++) begin
      x.data = d[k]; x.gnt = 4'(1 << r); x.rdy = 4'(1 << r);
      expq.push_back(x);
    end
    refreshReq();
  endtask

  task automatic applyReset();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    consumed = '0;
    expq.delete();
    refreshReq();
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(active == 1'b0 && expq.size() == 0) && n < 400);
    checkOutput(name, {31'd0, active}, 32'd0);
    checkOutput({name, "_drained"}, expq.size(), 32'd0);
  endtask

  // Requester queues and the transmitter model advance just after each edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) if (consumed[i]) rhead[i]++;
    consumed = '0;
    if (tx_done) tx_done = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        model_busy = 1'b0;
        tx_done    = done_en;
      end
    end
    if (start_seen) begin
      model_busy = 1'b1;
      busy_cnt   = BYTE_CYC;
    end
    start_seen = 1'b0;
    tx_busy    = model_busy;
    refreshReq();
  end

  // Scoreboard monitor: every start must match the next expected byte.
  always @(negedge clk) begin
    if (tx_start) begin
      start_seen = 1'b1;
      start_cyc  = cyc;
      checkOutput("start_while_busy", {31'd0, tx_busy}, 32'd0);
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_start: got tx_data %0h expected no start", tx_data);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
        checkOutput("grant_at_start", {28'd0, grant}, {28'd0, mon_e.gnt});
        checkOutput("req_ready_at_start", {28'd0, req_ready}, {28'd0, mon_e.rdy});
      end
    end else if (req_ready != 4'b0000) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL stray_ready: got %0h expected 0", req_ready);
    end
    for (int i = 0; i < NR; i++) if (req_ready[i]) ready_cnt[i]++;
    consumed = req_ready;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    rst = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0; model_busy = 1'b0; busy_cnt = 0;
    done_en = 1'b1; start_seen = 1'b0; consumed = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    r2_valid = '0; r2_last = '0; r2_data = '0; tx2_busy = 1'b0; tx2_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rhead[i] = 0; rtail[i] = 0; ready_cnt[i] = 0;
    end
    refreshReq();

    #12;
    checkOutput("rst_grant", {28'd0, grant}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst = 1'b1;

    $display("[TB] single frame");
    applyStimulus(1, 2, 8'h55, 8'h3C, 8'h00, 1'b1, 2);
    waitIdle("single_idle");
    checkOutput("single_grant", {28'd0, grant}, 32'd0);
    checkOutput("single_ready_cnt", ready_cnt[1], 32'd2);
    checkOutput("single_ptr", {30'd0, dut.ptr}, 32'd1);

    $display("[TB] fairness");
    @(negedge clk); applyReset();
    @(negedge clk); rst = 1'b1;
    for (int r = 0; r < NR; r++) applyStimulus(r, 1, 8'h10 + 8'(r), 8'h00, 8'h00, 1'b1, 1);
    for (int r = 0; r < NR; r++) applyStimulus(r, 1, 8'h20 + 8'(r), 8'h00, 8'h00, 1'b1, 1);
    waitIdle("fair_idle");

    $display("[TB] lock");
    applyStimulus(2, 3, 8'h71, 8'h72, 8'h73, 1'b1, 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant != 4'b0100 && n < 50);
    checkOutput("lock_grant2", {28'd0, grant}, 32'h4);
    applyStimulus(0, 1, 8'h05, 8'h00, 8'h00, 1'b1, 1);
    waitIdle("lock_idle");

    $display("[TB] watchdog");
    done_en = 1'b0;
    applyStimulus(1, 1, 8'h99, 8'h00, 8'h00, 1'b1, 0);
    applyStimulus(2, 1, 8'h42, 8'h00, 8'h00, 1'b1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 100);
    checkOutput("wd_err_seen", {31'd0, err}, 32'd1);
    checkOutput("wd_err_delay", cyc - start_cyc, 32'd21);
    checkOutput("wd_grant", {28'd0, grant}, 32'd0);
    done_en = 1'b1;
    applyStimulus(1, 1, 8'h99, 8'h00, 8'h00, 1'b0, 1);
    @(negedge clk);
    checkOutput("wd_err_pulse", {31'd0, err}, 32'd0);
    waitIdle("wd_idle");

    $display("[TB] reset mid-frame");
    applyStimulus(3, 2, 8'h61, 8'h62, 8'h00, 1'b1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_start && tx_data == 8'h61) && n < 100);
    checkOutput("mid_reached_byte", {24'd0, tx_data}, 32'h61);
    @(negedge clk);
    #2;
    applyReset();
    #1;
    checkOutput("mid_grant", {28'd0, grant}, 32'd0);
    checkOutput("mid_active", {31'd0, active}, 32'd0);
    checkOutput("mid_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("mid_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("mid_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("mid_err", {31'd0, err}, 32'd0);
    applyStimulus(0, 1, 8'h07, 8'h00, 8'h00, 1'b1, 1);
    applyStimulus(2, 1, 8'h08, 8'h00, 8'h00, 1'b1, 1);
    @(negedge clk); rst = 1'b1;
    waitIdle("mid_idle");

    $display("[TB] busy without header");
    @(posedge clk); #2;
    r2_valid = 4'b0010; r2_data = 32'h00005A00; r2_last = 4'b0010; tx2_busy = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("busy_hold_start", {31'd0, tx2_start}, 32'd0);
      checkOutput("busy_hold_grant", {28'd0, grant2}, 32'h2);
    end
    @(posedge clk); #2; tx2_busy = 1'b0;
    @(negedge clk);
    checkOutput("busy_fire_start", {31'd0, tx2_start}, 32'd1);
    checkOutput("busy_fire_data", {24'd0, tx2_data}, 32'h5A);
    checkOutput("busy_fire_ready", {28'd0, r2_ready}, 32'h2);
    @(posedge clk); #2; tx2_busy = 1'b1; r2_valid = '0; r2_last = '0; r2_data = '0;
    @(negedge clk);
    checkOutput("busy_single_fire", {31'd0, tx2_start}, 32'd0);
    @(posedge clk); #2; tx2_busy = 1'b0; tx2_done = 1'b1;
    @(posedge clk); #2; tx2_done = 1'b0;
    @(negedge clk);
    checkOutput("nohdr_grant_clear", {28'd0, grant2}, 32'd0);
    checkOutput("nohdr_active_clear", {31'd0, active2}, 32'd0);
    checkOutput("nohdr_no_err", {31'd0, err2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
